// File: rtl/bf_io_port.sv
// Byte I/O peripheral for the brainfuck CPU: CPU writes feed a TX FIFO, CPU reads drain an RX FIFO.
// The CPU is stalled by withholding io_ack. io_ack rises at the edge that performs the push or pop.
module bf_io_port #(
  parameter int tx_depth_log2 = 3,
  parameter int rx_depth_log2 = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     io_req,
  input  logic                     io_dir,
  input  logic [7:0]               io_wdata,
  output logic                     io_ack,
  output logic [7:0]               io_rdata,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic [tx_depth_log2:0]   tx_count,
  output logic [rx_depth_log2:0]   rx_count
);

  localparam int TxDepth = 1 << tx_depth_log2;
  localparam int RxDepth = 1 << rx_depth_log2;
  localparam logic [tx_depth_log2-1:0] TxPtrOne = (tx_depth_log2)'(1);
  localparam logic [rx_depth_log2-1:0] RxPtrOne = (rx_depth_log2)'(1);
  localparam logic [tx_depth_log2:0]   TxCntOne = (tx_depth_log2 + 1)'(1);
  localparam logic [rx_depth_log2:0]   RxCntOne = (rx_depth_log2 + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_W_WAIT, S_R_WAIT, S_ACK} state_e;

  state_e state_q;
  logic   ack_q;
  logic [7:0] rdata_q;

  logic [7:0]               tx_mem [TxDepth];
  logic [tx_depth_log2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [tx_depth_log2:0]   tx_cnt_q, tx_cnt_d;

  logic [7:0]               rx_mem [RxDepth];
  logic [rx_depth_log2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [rx_depth_log2:0]   rx_cnt_q, rx_cnt_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic cpu_push, cpu_pop, sink_pop, src_push;

  // Occupancy never exceeds depth, so the count MSB alone means full.
  assign tx_full  = tx_cnt_q[tx_depth_log2];
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = rx_cnt_q[rx_depth_log2];
  assign rx_empty = (rx_cnt_q == '0);

  assign cpu_push = io_req && !tx_full &&
                    ((state_q == S_IDLE && io_dir) || state_q == S_W_WAIT);
  assign cpu_pop  = io_req && !rx_empty &&
                    ((state_q == S_IDLE && !io_dir) || state_q == S_R_WAIT);
  assign sink_pop = !tx_empty && tx_ready;
  assign src_push = !rx_full && rx_valid;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_q];
  assign rx_ready = !rx_full;
  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
  assign io_ack   = ack_q;
  assign io_rdata = rdata_q;

  always_comb begin
    tx_wr_d  = cpu_push ? tx_wr_q + TxPtrOne : tx_wr_q;
    tx_rd_d  = sink_pop ? tx_rd_q + TxPtrOne : tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    case ({cpu_push, sink_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TxCntOne;
      2'b01:   tx_cnt_d = tx_cnt_q - TxCntOne;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    rx_wr_d  = src_push ? rx_wr_q + RxPtrOne : rx_wr_q;
    rx_rd_d  = cpu_pop  ? rx_rd_q + RxPtrOne : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    case ({src_push, cpu_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RxCntOne;
      2'b01:   rx_cnt_d = rx_cnt_q - RxCntOne;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_push) tx_mem[tx_wr_q] <= io_wdata;
    if (src_push) rx_mem[rx_wr_q] <= rx_data;
  end

  // A completed push/pop overrides the wait-state choice made in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: if (io_req) state_q <= io_dir ? S_W_WAIT : S_R_WAIT;
        S_ACK: begin
          if (!io_req) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
      if (cpu_push || cpu_pop) begin
        ack_q   <= 1'b1;
        state_q <= S_ACK;
      end
      if (cpu_pop) rdata_q <= rx_mem[rx_rd_q];
    end
  end

endmodule

// File: tb/tb_bf_io_port.sv
// Bench for bf_io_port: queue-based transaction model checked every cycle, plus directed literal checks.
module tb_bf_io_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic io_req = 1'b0, io_dir = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] io_wdata = 8'h00, rx_data = 8'h00;
  logic io_ack, tx_valid, rx_ready;
  logic [7:0] io_rdata, tx_data;
  logic [3:0] tx_count, rx_count;

  bf_io_port #(.tx_depth_log2(3), .rx_depth_log2(3)) dut (
    .clk(clk), .rst_n(rst_n), .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFOs as queues, CPU side as "request outstanding / acknowledged".
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  logic       m_ack;
  logic [7:0] m_rdata;
  int         m_ts, m_rs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txq.delete();
      m_rxq.delete();
      m_ack   = 1'b0;
      m_rdata = 8'h00;
    end else begin
      m_ts = m_txq.size();
      m_rs = m_rxq.size();
      if (tx_ready && m_ts > 0) void'(m_txq.pop_front());
      if (rx_valid && m_rs < 8) m_rxq.push_back(rx_data);
      if (m_ack) begin
        if (!io_req) m_ack = 1'b0;
      end else if (io_req) begin
        if (io_dir && m_ts < 8) begin
          m_txq.push_back(io_wdata);
          m_ack = 1'b1;
        end else if (!io_dir && m_rs > 0) begin
          m_rdata = m_rxq.pop_front();
          m_ack   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ack", io_ack, m_ack);
      chk("m_rdata", io_rdata, m_rdata);
      chk("m_tx_count", tx_count, m_txq.size());
      chk("m_rx_count", rx_count, m_rxq.size());
      chk("m_tx_valid", tx_valid, m_txq.size() != 0);
      chk("m_rx_ready", rx_ready, m_rxq.size() < 8);
      if (m_txq.size() != 0) chk("m_tx_data", tx_data, m_txq[0]);
    end
  end

  // Sink-side log of delivered bytes with the cycle they left.
  int cyc = 0;
  logic [7:0] slog[$];
  int         scyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      slog.push_back(tx_data);
      scyc.push_back(cyc);
    end
  end

  task automatic chk_log(input string nm, input int idx, input logic [7:0] exp);
    if (idx < slog.size()) chk(nm, slog[idx], exp);
    else chk(nm, 32'hdead, exp);
  endtask

  task automatic wait_ack(input logic val);
    int n = 0;
    while (io_ack !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (io_ack !== val) chk("ack_timeout", io_ack, val);
  endtask

  task automatic cpu_xfer(input logic dir, input logic [7:0] wd, output int c, output logic [7:0] rd);
    io_req = 1'b1;
    io_dir = dir;
    io_wdata = wd;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!io_ack && c < 50);
    if (!io_ack) chk("xfer_timeout", io_ack, 1);
    rd = io_rdata;
    io_req = 1'b0;
    wait_ack(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    logic [7:0] r;

    #1;
    chk("rst_ack", io_ack, 0);
    chk("rst_rdata", io_rdata, 8'h00);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_rx_ready", rx_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while the second write sits in ACK.
    cpu_xfer(1'b1, 8'h48, c, r);
    io_req = 1'b1; io_dir = 1'b1; io_wdata = 8'h69;
    @(negedge clk);
    chk("midack_ack", io_ack, 1);
    chk("midack_cnt", tx_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midack_rst_ack", io_ack, 0);
    chk("midack_rst_txc", tx_count, 0);
    chk("midack_rst_rxc", rx_count, 0);
    chk("midack_rst_txv", tx_valid, 0);
    chk("midack_rst_rxr", rx_ready, 1);
    io_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two writes held in TX, then streamed on consecutive cycles.
    cpu_xfer(1'b1, 8'h48, c, r);
    chk("hi_lat0", c, 1);
    cpu_xfer(1'b1, 8'h69, c, r);
    chk("hi_lat1", c, 1);
    chk("hi_cnt", tx_count, 2);
    base = slog.size();
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tx_ready = 1'b0;
    chk_log("hi_b0", base, 8'h48);
    chk_log("hi_b1", base + 1, 8'h69);
    chk("hi_n", slog.size() - base, 2);
    if (slog.size() >= base + 2) chk("hi_consec", scyc[base + 1] - scyc[base], 1);

    // Fill TX, ninth write stalls until the sink frees a slot.
    for (int i = 0; i < 8; i++) cpu_xfer(1'b1, 8'(8'h10 + i), c, r);
    chk("full_cnt", tx_count, 8);
    io_req = 1'b1; io_dir = 1'b1; io_wdata = 8'h99;
    repeat (3) @(negedge clk);
    chk("ww_noack", io_ack, 0);
    chk("ww_cnt", tx_count, 8);
    base = slog.size();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("ww_pop_noack", io_ack, 0);
    chk("ww_pop_cnt", tx_count, 7);
    @(negedge clk);
    chk("ww_ack", io_ack, 1);
    chk("ww_cnt8", tx_count, 8);
    io_req = 1'b0;
    wait_ack(1'b0);
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) chk_log("ww_order", base + i, 8'(8'h10 + i));
    chk_log("ww_ninth", base + 8, 8'h99);

    // Read with RX empty waits for the source, no bypass.
    io_req = 1'b1; io_dir = 1'b0;
    repeat (3) @(negedge clk);
    chk("rw_noack", io_ack, 0);
    rx_valid = 1'b1; rx_data = 8'h41;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rw_push_noack", io_ack, 0);
    chk("rw_push_cnt", rx_count, 1);
    @(negedge clk);
    chk("rw_ack", io_ack, 1);
    chk("rw_rdata", io_rdata, 8'h41);
    chk("rw_cnt", rx_count, 0);
    io_req = 1'b0;
    wait_ack(1'b0);

    // Fill RX, hold a ninth byte, then drain through the wrap.
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data = 8'(i);
      @(negedge clk);
    end
    rx_data = 8'h08;
    repeat (2) @(negedge clk);
    chk("rxf_ready", rx_ready, 0);
    chk("rxf_cnt", rx_count, 8);
    io_req = 1'b1; io_dir = 1'b0;
    @(negedge clk);
    chk("rxf_ack", io_ack, 1);
    chk("rxf_rdata", io_rdata, 8'h00);
    chk("rxf_ready1", rx_ready, 1);
    chk("rxf_cnt7", rx_count, 7);
    io_req = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rxf_held_cnt", rx_count, 8);
    chk("rxf_ack0", io_ack, 0);
    for (int i = 1; i <= 8; i++) begin
      cpu_xfer(1'b0, 8'h00, c, r);
      chk("rxf_order", r, 8'(i));
    end
    chk("rxf_rdata_hold", io_rdata, 8'h08);

    // Same-cycle CPU push and sink pop at occupancy 3.
    cpu_xfer(1'b1, 8'hA0, c, r);
    cpu_xfer(1'b1, 8'hA1, c, r);
    cpu_xfer(1'b1, 8'hA2, c, r);
    chk("sim_cnt3", tx_count, 3);
    base = slog.size();
    io_req = 1'b1; io_dir = 1'b1; io_wdata = 8'hA3; tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("sim_ack", io_ack, 1);
    chk("sim_cnt", tx_count, 3);
    io_req = 1'b0;
    wait_ack(1'b0);
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    tx_ready = 1'b0;
    chk_log("sim_b0", base, 8'hA0);
    chk_log("sim_b1", base + 1, 8'hA1);
    chk_log("sim_b2", base + 2, 8'hA2);
    chk_log("sim_b3", base + 3, 8'hA3);
    chk("sim_empty", tx_count, 0);
    chk("sim_rdata_hold", io_rdata, 8'h08);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
